sseg_mux_bcd: RTL and testbench

SSEG_MUX_BCD -- requirements
Module: sseg_mux_bcd

---
 rtl/sseg_mux_bcd.sv | 83 ++++++++
 tb/tb_sseg_mux_bcd.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_bcd.sv
// sseg_mux_bcd: four-digit multiplexed BCD seven-segment driver with per-frame
// input shadowing, leading-zero blanking and registered active-low outputs.
module sseg_mux_bcd #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] LAST = W'(REFRESH_DIV - 1);
  logic [W-1:0] presc_q, presc_d;
  logic [1:0]   idx_q, idx_d;
  logic [15:0]  sh_bcd_q, sh_bcd_d;
  logic [3:0]   sh_dp_q, sh_dp_d;
  logic [3:0]   an_q, an_d;
  logic [6:0]   sseg_q, sseg_d, pat;
  logic         dp_q, dp_d, ft_q, ft_d;
  logic         tick, cap, blank;
  logic [3:0]   dig, zero, lz;
  assign an = an_q;
  assign sseg = sseg_q;
  assign dp = dp_q;
  assign frame_tick = ft_q;
  always_comb begin
    tick = enable && presc_q == LAST;
    cap = tick && idx_q == 2'd3;
    presc_d = !enable ? presc_q : tick ? '0 : presc_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    sh_bcd_d = cap ? bcd : sh_bcd_q;
    sh_dp_d = cap ? dp_in : sh_dp_q;
    ft_d = cap;
    dig = sh_bcd_q[{idx_q, 2'b00} +: 4];
    zero = {sh_bcd_q[15:12] == 4'd0, sh_bcd_q[11:8] == 4'd0, sh_bcd_q[7:4] == 4'd0, sh_bcd_q[3:0] == 4'd0};
    // lz[i]: digit i and every digit above it are zero; digit 0 is never a leading zero
    lz = {zero[3], &zero[3:2], &zero[3:1], 1'b0};
    blank = blank_lz && lz[idx_q] && !sh_dp_q[idx_q];
    case (dig)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
    sseg_d = blank ? 7'h7F : pat;
    an_d = ~(4'b0001 << idx_q);
    dp_d = ~sh_dp_q[idx_q];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q <= 2'd0;
      sh_bcd_q <= 16'h0000;
      sh_dp_q <= 4'h0;
      an_q <= 4'hF;
      sseg_q <= 7'h7F;
      dp_q <= 1'b1;
      ft_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      sh_bcd_q <= sh_bcd_d;
      sh_dp_q <= sh_dp_d;
      an_q <= an_d;
      sseg_q <= sseg_d;
      dp_q <= dp_d;
      ft_q <= ft_d;
    end
  end
endmodule

// File: tb/tb_sseg_mux_bcd.sv
// tb_sseg_mux_bcd: randomized and directed bench for sseg_mux_bcd against a
// time-based reference model (digit position derived from enabled-cycle count).
`timescale 1ns/1ps
module tb_sseg_mux_bcd;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic reset_n, enable, blank_lz;
  logic [15:0] bcd;
  logic [3:0] dp_in, an;
  logic [6:0] sseg;
  logic dp, frame_tick;
  int checks = 0;
  int failures = 0;
  sseg_mux_bcd #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bcd(bcd), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  logic [6:0] seg7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [6:0] ref_seg(logic [15:0] b, logic [3:0] p, int i, logic blz);
    int v;
    v = int'((b >> (4 * i)) & 16'hF);
    if (i > 0 && blz && (b >> (4 * i)) == 16'd0 && !p[i]) return 7'h7F;
    if (v > 9) return 7'h3F;
    return seg7[v];
  endfunction
  // Reference model: the digit on display follows from how many enabled cycles
  // have elapsed; the frame value is latched when the last digit's slot ends.
  int ecnt;
  int pos;
  logic cap_m;
  logic [15:0] sh_bcd;
  logic [3:0] sh_dp, e_an;
  logic [6:0] e_seg;
  logic e_dp, e_ft;
  logic [3:0] one = 4'b0001;
  assign pos = (ecnt / DIV) % 4;
  assign cap_m = enable && (ecnt % DIV == DIV - 1) && pos == 3;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ecnt <= 0;
      sh_bcd <= 16'h0;
      sh_dp <= 4'h0;
      e_an <= 4'hF;
      e_seg <= 7'h7F;
      e_dp <= 1'b1;
      e_ft <= 1'b0;
    end else begin
      e_an <= ~(one << pos);
      e_seg <= ref_seg(sh_bcd, sh_dp, pos, blank_lz);
      e_dp <= ~sh_dp[pos];
      e_ft <= cap_m;
      if (cap_m) begin
        sh_bcd <= bcd;
        sh_dp <= dp_in;
      end
      if (enable) ecnt <= ecnt + 1;
    end
  end
  logic [12:0] obs, mdl;
  assign obs = {an, sseg, dp, frame_tick};
  assign mdl = {e_an, e_seg, e_dp, e_ft};
  task automatic wait_ft();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    if (frame_tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_ft timeout: frame_tick=%b required 1", frame_tick);
    end
  endtask
  task automatic wait_an(input logic [3:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== a && n < 200);
    if (an !== a) begin
      checks++;
      failures++;
      $display("FAIL wait_an timeout: an=%h required %h", an, a);
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    bcd = 16'h0;
    dp_in = 4'h0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, sseg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got an=%h sseg=%h dp=%b ft=%b required F 7F 1 0", an, sseg, dp, frame_tick);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, sseg, dp} !== {4'hE, 7'h40, 1'b1}) begin
      failures++;
      $display("FAIL reset_release: got an=%h sseg=%h dp=%b required E 40 1", an, sseg, dp);
    end
    checks++;
    if (obs !== mdl) begin
      failures++;
      $display("FAIL reset_model: got %h required %h", obs, mdl);
    end
  endtask
  task automatic test_scan_order();
    logic [6:0] e [4];
    logic [3:0] a;
    e = '{7'h19, 7'h30, 7'h24, 7'h79};
    bcd = 16'h1234;
    dp_in = 4'h0;
    blank_lz = 1'b0;
    enable = 1'b1;
    wait_ft();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = ~(one << (k / 4));
      checks++;
      if (an !== a || sseg !== e[k / 4]) begin
        failures++;
        $display("FAIL scan_order k=%0d: got an=%h sseg=%h required %h %h", k, an, sseg, a, e[k / 4]);
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL scan_model k=%0d: got %h required %h", k, obs, mdl);
      end
    end
  endtask
  task automatic test_coherence();
    logic [6:0] e [4];
    e = '{7'h02, 7'h78, 7'h00, 7'h10};
    bcd = 16'h1234;
    wait_ft();
    wait_an(4'hD);
    bcd = 16'h9876;
    wait_an(4'hB);
    checks++;
    if (sseg !== 7'h24) begin
      failures++;
      $display("FAIL coherence_d2: got sseg=%h required 24", sseg);
    end
    wait_an(4'h7);
    checks++;
    if (sseg !== 7'h79) begin
      failures++;
      $display("FAIL coherence_d3: got sseg=%h required 79", sseg);
    end
    wait_ft();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (sseg !== e[k / 4] || obs !== mdl) begin
        failures++;
        $display("FAIL coherence_new k=%0d: got sseg=%h obs=%h required %h obs=%h", k, sseg, obs, e[k / 4], mdl);
      end
    end
  endtask
  task automatic test_blank();
    logic [6:0] e [4];
    logic [6:0] f [4];
    e = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    f = '{7'h40, 7'h78, 7'h40, 7'h7F};
    blank_lz = 1'b1;
    dp_in = 4'h0;
    bcd = 16'h0070;
    wait_ft();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (sseg !== e[k / 4] || dp !== 1'b1 || obs !== mdl) begin
        failures++;
        $display("FAIL blank k=%0d: got sseg=%h dp=%b required %h 1", k, sseg, dp, e[k / 4]);
      end
    end
    dp_in = 4'b0100;
    wait_ft();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (sseg !== f[k / 4] || dp !== (k / 4 != 2) || obs !== mdl) begin
        failures++;
        $display("FAIL blank_dp k=%0d: got sseg=%h dp=%b required %h %b", k, sseg, dp, f[k / 4], k / 4 != 2);
      end
    end
  endtask
  task automatic test_invalid();
    logic [6:0] e [4];
    e = '{7'h12, 7'h3F, 7'h40, 7'h3F};
    blank_lz = 1'b0;
    dp_in = 4'h0;
    bcd = 16'hA0F5;
    wait_ft();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (sseg !== e[k / 4] || obs !== mdl) begin
        failures++;
        $display("FAIL invalid k=%0d: got sseg=%h required %h", k, sseg, e[k / 4]);
      end
    end
  endtask
  task automatic test_hold();
    bcd = 16'h1234;
    wait_an(4'hB);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hB || frame_tick !== 1'b0 || obs !== mdl) begin
        failures++;
        $display("FAIL hold k=%0d: got an=%h ft=%b required B 0", k, an, frame_tick);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (an !== (k < 3 ? 4'hB : 4'h7) || obs !== mdl) begin
        failures++;
        $display("FAIL hold_resume k=%0d: got an=%h required %h", k, an, k < 3 ? 4'hB : 4'h7);
      end
    end
  endtask
  task automatic test_random();
    logic [15:0] masks [4];
    masks = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL random k=%0d: got %h required %h", k, obs, mdl);
      end
      bcd = 16'($urandom) & masks[$urandom_range(3)];
      dp_in = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      enable = $urandom_range(9) != 0;
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
    end
    enable = 1'b1;
  endtask
  task automatic test_reset_mid();
    bcd = 16'h1234;
    wait_an(4'h7);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({an, sseg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got an=%h sseg=%h dp=%b ft=%b required F 7F 1 0", an, sseg, dp, frame_tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'hE || sseg !== 7'h40 || obs !== mdl) begin
      failures++;
      $display("FAIL reset_mid_release: got an=%h sseg=%h required E 40", an, sseg);
    end
  endtask
  initial begin
    test_reset();
    test_scan_order();
    test_coherence();
    test_blank();
    test_invalid();
    test_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
